// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: NOP encoding, default reset PC
// and the layout of a buffered fetch entry.
package if_fetch_unit_pkg;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc_plus4;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/if_fetch_unit_fetch_fifo.sv
// Small synchronous FIFO with a flush that empties it in one cycle; used both for the
// in-flight PC side queue and for the returned-instruction buffer.
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // A push into a full FIFO is accepted only when the head leaves in the same cycle.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= next_ptr(wr_ptr);
         if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues credit-limited in-order imem requests and
// presents the oldest buffered word to the IF/ID register, honouring stall and redirect.
module if_fetch_unit
   import if_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
   parameter int          DEPTH           = 2,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        Stall_i,
   input  logic        Redirect_i,
   input  logic [31:0] RedirectPC_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] PC_o,
   output logic [31:0] instruction_o,
   output logic        valid_o
);

   localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [31:0]      pc;
   logic [OUT_W-1:0] outstanding;
   logic [OUT_W-1:0] outstanding_next;
   logic [OUT_W-1:0] drop;
   logic             issue;
   logic             drop_word;
   logic             accept_word;
   logic             pop_head;
   logic [31:0]      side_head;
   logic             side_full;
   logic             side_empty;
   logic [OUT_W-1:0] side_count;
   fetch_entry_t     push_entry;
   fetch_entry_t     head;
   logic             buf_full;
   logic             buf_empty;
   logic [CNT_W-1:0] buf_count;

   // Every granted request already owns a buffer slot, so the buffer can never overflow.
   assign imem_req_o = rst_i && !Redirect_i
                       && ((32'(outstanding) + 32'(buf_count)) < 32'(DEPTH))
                       && (32'(outstanding) < 32'(MAX_OUTSTANDING));
   assign imem_addr_o      = pc;
   assign issue            = imem_req_o && imem_gnt_i;
   assign drop_word        = imem_rvalid_i && (drop != '0);
   assign accept_word      = imem_rvalid_i && (drop == '0) && !Redirect_i;
   assign pop_head         = !buf_empty && !Stall_i && !Redirect_i;
   assign outstanding_next = outstanding + OUT_W'(issue) - OUT_W'(imem_rvalid_i);
   assign push_entry       = '{pc_plus4: side_head, instr: imem_rdata_i};

   assign valid_o       = !buf_empty;
   assign instruction_o = buf_empty ? NOP_INSTR : head.instr;
   assign PC_o          = buf_empty ? 32'h0 : head.pc_plus4;

   fetch_fifo #(.DEPTH(MAX_OUTSTANDING), .WIDTH(32)) u_side_queue (
      .clk   (clk_i),
      .rst_n (rst_i),
      .push  (issue),
      .pop   (accept_word),
      .flush (Redirect_i),
      .wdata (pc + 32'd4),
      .rdata (side_head),
      .full  (side_full),
      .empty (side_empty),
      .count (side_count)
   );

   fetch_fifo #(.DEPTH(DEPTH), .WIDTH($bits(fetch_entry_t))) u_instr_buf (
      .clk   (clk_i),
      .rst_n (rst_i),
      .push  (accept_word),
      .pop   (pop_head),
      .flush (Redirect_i),
      .wdata (push_entry),
      .rdata (head),
      .full  (buf_full),
      .empty (buf_empty),
      .count (buf_count)
   );

   // On redirect every request still unanswered after this edge belongs to the old path.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         pc          <= RESET_PC;
         outstanding <= '0;
         drop        <= '0;
      end else begin
         outstanding <= outstanding_next;
         if (Redirect_i) begin
            pc   <= RedirectPC_i & ~32'h3;
            drop <= outstanding_next;
         end else begin
            if (issue)     pc   <= pc + 32'd4;
            if (drop_word) drop <= drop - OUT_W'(1);
         end
      end
   end

   // Live side-queue entries are exactly the requests that will not be discarded.
   a_side_tracks_live: assert property (@(posedge clk_i) disable iff (!rst_i)
      side_count == (outstanding - drop));
   a_side_not_full_on_issue: assert property (@(posedge clk_i) disable iff (!rst_i)
      !(issue && side_full));
   a_side_has_pc_on_accept: assert property (@(posedge clk_i) disable iff (!rst_i)
      !(accept_word && side_empty));
   a_buf_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_i)
      !(accept_word && buf_full && !pop_head));

endmodule
